// File: rtl/df_ctrl_pkg.sv
// df_ctrl_pkg: shared constants and types for the dataflow controller
// configuration path.
//   - SAURIA_NARGS : number of 64-bit SAURIA arguments (two 32-bit words each)
//   - register offsets of the controller's AXI-Lite slave
//   - bit patterns written to CTRL / IEN / ISTAT
//   - seq_state_t  : states of the job sequencer FSM
package df_ctrl_pkg;

    localparam int SAURIA_NARGS = 4;

    localparam logic [31:0] REG_CTRL     = 32'h0000_0000;
    localparam logic [31:0] REG_IEN      = 32'h0000_0008;
    localparam logic [31:0] REG_ISTAT    = 32'h0000_000C;
    localparam logic [31:0] REG_ARG_BASE = 32'h0000_0010;

    localparam logic [31:0] CTRL_START    = 32'h0000_0001;
    localparam logic [31:0] CTRL_DONE_CLR = 32'h0000_0002;
    localparam logic [31:0] IEN_ENABLE    = 32'h0000_0001;
    localparam logic [31:0] ISTAT_CLR     = 32'h0000_0001;

    localparam logic [3:0]  WSTRB_ALL     = 4'hF;

    typedef enum logic [2:0] {
        SEQ_INIT     = 3'd0,
        SEQ_IDLE     = 3'd1,
        SEQ_CFG      = 3'd2,
        SEQ_START    = 3'd3,
        SEQ_WAIT     = 3'd4,
        SEQ_CLR_INT  = 3'd5,
        SEQ_CLR_DONE = 3'd6
    } seq_state_t;

endpackage

// File: rtl/df_axil_single_write.sv
// df_axil_single_write: issues one AXI-Lite write at a time.
//   req/addr/data : held by the requester until ack; addr/data must stay stable
//   ack           : one cycle, the cycle the write response is accepted
//   resp          : bresp of that response (valid with ack)
//   m_aw*/m_w*/m_b* : AXI-Lite write channels toward the slave
// AW and W are raised together and dropped together after the joint
// handshake; bready is then held until bvalid.
module df_axil_single_write
    import df_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           data,
    output logic                  ack,
    output logic [1:0]            resp,
    output logic                  m_awvalid_o,
    input  logic                  m_awready_i,
    output logic [ADDR_WIDTH-1:0] m_awaddr_o,
    output logic                  m_wvalid_o,
    input  logic                  m_wready_i,
    output logic [31:0]           m_wdata_o,
    output logic [3:0]            m_wstrb_o,
    input  logic                  m_bvalid_i,
    output logic                  m_bready_o,
    input  logic [1:0]            m_bresp_i
);

    // armed keeps the valids low while reset is applied and for the first
    // cycle after it, even though the sequencer already requests in INIT.
    logic armed;
    logic wait_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed  <= 1'b0;
            wait_b <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (m_awvalid_o && m_awready_i && m_wready_i) begin
                wait_b <= 1'b1;
            end else if (wait_b && m_bvalid_i) begin
                wait_b <= 1'b0;
            end
        end
    end

    // Valids come straight from the request so a write costs only the
    // handshake cycle plus the response cycle.
    assign m_awvalid_o = armed && req && !wait_b;
    assign m_wvalid_o  = m_awvalid_o;
    assign m_awaddr_o  = addr;
    assign m_wdata_o   = data;
    assign m_wstrb_o   = WSTRB_ALL;
    assign m_bready_o  = wait_b;
    assign ack         = wait_b && m_bvalid_i;
    assign resp        = m_bresp_i;

endmodule

// File: rtl/df_job_sequencer.sv
// df_job_sequencer: job FIFO + sequencer in front of the dataflow controller's
// AXI-Lite configuration slave. For each queued register set it writes the
// argument words, pulses start, waits for the interrupt (or watchdog), then
// clears the interrupt and done bits.
//   job_valid_i/job_ready_o/job_data_i : job push interface
//   ctrl_intr_i                        : controller interrupt (level)
//   m_aw*/m_w*/m_b*/m_arvalid_o/m_rready_o : AXI-Lite master (reads unused)
//   busy_o, job_done_o, timeout_o, resp_err_o, fifo_count_o : status
module df_job_sequencer
    import df_ctrl_pkg::*;
#(
    parameter int N_REGS         = SAURIA_NARGS * 2,
    parameter int JOB_DEPTH      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         job_valid_i,
    output logic                         job_ready_o,
    input  logic [N_REGS*32-1:0]         job_data_i,
    input  logic                         ctrl_intr_i,
    output logic                         m_awvalid_o,
    input  logic                         m_awready_i,
    output logic [ADDR_WIDTH-1:0]        m_awaddr_o,
    output logic                         m_wvalid_o,
    input  logic                         m_wready_i,
    output logic [31:0]                  m_wdata_o,
    output logic [3:0]                   m_wstrb_o,
    input  logic                         m_bvalid_i,
    output logic                         m_bready_o,
    input  logic [1:0]                   m_bresp_i,
    output logic                         m_arvalid_o,
    output logic                         m_rready_o,
    output logic                         busy_o,
    output logic                         job_done_o,
    output logic                         timeout_o,
    output logic                         resp_err_o,
    output logic [$clog2(JOB_DEPTH):0]   fifo_count_o
);

    localparam int PW = (JOB_DEPTH > 1) ? $clog2(JOB_DEPTH) : 1;
    localparam int CW = $clog2(JOB_DEPTH) + 1;
    localparam int IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    localparam logic [2:0] ST_INIT     = SEQ_INIT;
    localparam logic [2:0] ST_IDLE     = SEQ_IDLE;
    localparam logic [2:0] ST_CFG      = SEQ_CFG;
    localparam logic [2:0] ST_START    = SEQ_START;
    localparam logic [2:0] ST_WAIT     = SEQ_WAIT;
    localparam logic [2:0] ST_CLR_INT  = SEQ_CLR_INT;
    localparam logic [2:0] ST_CLR_DONE = SEQ_CLR_DONE;

    logic [2:0]           state;
    logic [IW-1:0]        idx;
    logic [31:0]          wd_cnt;
    logic                 timed_out;

    logic [N_REGS*32-1:0] mem [JOB_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 push;
    logic                 pop;
    logic [31:0]          head_word;

    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  wr_ack;
    logic [1:0]            wr_resp;

    // Readiness uses the registered count only, so a full FIFO refuses a
    // push even in the cycle it pops.
    assign job_ready_o  = (count < CW'(JOB_DEPTH));
    assign push         = job_valid_i && job_ready_o;
    assign pop          = (state == ST_START) && wr_ack;
    assign fifo_count_o = count;
    // The head slot is never overwritten while non-empty, so the data
    // presented during CFG stays stable across a stalled handshake.
    assign head_word    = mem[rd_ptr][{idx, 5'b0} +: 32];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= job_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(JOB_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(JOB_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        wr_req  = 1'b1;
        wr_addr = ADDR_WIDTH'(REG_CTRL);
        wr_data = CTRL_START;
        case (state)
            ST_INIT: begin
                wr_addr = ADDR_WIDTH'(REG_IEN);
                wr_data = IEN_ENABLE;
            end
            ST_CFG: begin
                wr_addr = ADDR_WIDTH'(REG_ARG_BASE) + (ADDR_WIDTH'(idx) << 2);
                wr_data = head_word;
            end
            ST_START: begin
                wr_addr = ADDR_WIDTH'(REG_CTRL);
                wr_data = CTRL_START;
            end
            ST_CLR_INT: begin
                wr_addr = ADDR_WIDTH'(REG_ISTAT);
                wr_data = ISTAT_CLR;
            end
            ST_CLR_DONE: begin
                wr_addr = ADDR_WIDTH'(REG_CTRL);
                wr_data = CTRL_DONE_CLR;
            end
            default: wr_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_INIT;
            idx        <= '0;
            wd_cnt     <= '0;
            timed_out  <= 1'b0;
            job_done_o <= 1'b0;
            timeout_o  <= 1'b0;
            resp_err_o <= 1'b0;
        end else begin
            job_done_o <= 1'b0;
            timeout_o  <= 1'b0;
            if (wr_ack && (wr_resp != 2'b00)) begin
                resp_err_o <= 1'b1;
            end
            case (state)
                ST_INIT: begin
                    if (wr_ack) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (count != '0) begin
                        state <= ST_CFG;
                        idx   <= '0;
                    end
                end
                ST_CFG: begin
                    if (wr_ack) begin
                        if (idx == IW'(N_REGS - 1)) state <= ST_START;
                        else                        idx   <= idx + 1'b1;
                    end
                end
                ST_START: begin
                    if (wr_ack) begin
                        state     <= ST_WAIT;
                        wd_cnt    <= '0;
                        timed_out <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (ctrl_intr_i) begin
                        state <= ST_CLR_INT;
                    end else if ((TIMEOUT_CYCLES != 0) &&
                                 (wd_cnt == 32'(TIMEOUT_CYCLES - 1))) begin
                        state     <= ST_CLR_INT;
                        timeout_o <= 1'b1;
                        timed_out <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                ST_CLR_INT: begin
                    if (wr_ack) state <= ST_CLR_DONE;
                end
                ST_CLR_DONE: begin
                    if (wr_ack) begin
                        state      <= ST_IDLE;
                        job_done_o <= !timed_out;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign busy_o      = (state != ST_INIT) && (state != ST_IDLE);
    assign m_arvalid_o = 1'b0;
    assign m_rready_o  = 1'b1;

    df_axil_single_write #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr (
        .clk         (clk),
        .rst         (rst),
        .req         (wr_req),
        .addr        (wr_addr),
        .data        (wr_data),
        .ack         (wr_ack),
        .resp        (wr_resp),
        .m_awvalid_o (m_awvalid_o),
        .m_awready_i (m_awready_i),
        .m_awaddr_o  (m_awaddr_o),
        .m_wvalid_o  (m_wvalid_o),
        .m_wready_i  (m_wready_i),
        .m_wdata_o   (m_wdata_o),
        .m_wstrb_o   (m_wstrb_o),
        .m_bvalid_i  (m_bvalid_i),
        .m_bready_o  (m_bready_o),
        .m_bresp_i   (m_bresp_i)
    );

endmodule

// File: tb/tb_df_job_sequencer.sv
// Bench for df_job_sequencer: the stimulus process pushes jobs and appends the
// write stream each job must produce to a scoreboard queue; a separate
// slave/monitor process acts as the AXI-Lite slave and controller interrupt,
// popping and comparing every accepted write and every completion pulse.
module tb_df_job_sequencer;
    import df_ctrl_pkg::*;

    localparam int NR = SAURIA_NARGS * 2;
    localparam int JD = 2;
    localparam int AW = 32;
    localparam int TO = 100;
    localparam int CW = $clog2(JD) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic job_valid = 1'b0;
    logic [NR*32-1:0] job_data = '0;
    logic job_ready;
    logic ctrl_intr = 1'b0;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [AW-1:0] awaddr;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic [1:0] bresp = 2'b00;
    logic busy, job_done, timeout, resp_err;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    df_job_sequencer #(
        .N_REGS(NR), .JOB_DEPTH(JD), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid_i(job_valid), .job_ready_o(job_ready), .job_data_i(job_data),
        .ctrl_intr_i(ctrl_intr),
        .m_awvalid_o(awvalid), .m_awready_i(awready), .m_awaddr_o(awaddr),
        .m_wvalid_o(wvalid), .m_wready_i(wready), .m_wdata_o(wdata), .m_wstrb_o(wstrb),
        .m_bvalid_i(bvalid), .m_bready_o(bready), .m_bresp_i(bresp),
        .m_arvalid_o(arvalid), .m_rready_o(rready),
        .busy_o(busy), .job_done_o(job_done), .timeout_o(timeout),
        .resp_err_o(resp_err), .fifo_count_o(fifo_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_wr[$];   // {addr, data} in required order
    int exp_end[$];           // per job: 0 = job_done pulse, 1 = timeout pulse
    int job_dly[$];           // per job: interrupt delay after WAIT entry, -1 = never
    logic exp_err = 1'b0;
    logic inject_err = 1'b0;
    int cyc = 0;
    int wait_start = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Behavioural model: every accepted job yields its argument words at
    // 0x10+4i in order, then start, interrupt clear and done clear.
    task automatic expect_job(input logic [NR*32-1:0] d, input int dly);
        for (int i = 0; i < NR; i++)
            exp_wr.push_back({32'h10 + 32'(4 * i), d[32*i +: 32]});
        exp_wr.push_back({32'h0, 32'h1});
        exp_wr.push_back({32'hC, 32'h1});
        exp_wr.push_back({32'h0, 32'h2});
        exp_end.push_back((dly < 0) ? 1 : 0);
        job_dly.push_back(dly);
    endtask

    // ---------------- AXI-Lite slave, interrupt source and monitor ----------
    int sph = 0, k = 0, da = 0, dw = 0, db = 0, bc = 0;
    logic [31:0] cap_a = '0, cap_d = '0;
    int intr_timer = -1;

    initial begin
        int e;
        int dl;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                sph = 0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                bresp = 2'b00; ctrl_intr = 1'b0; intr_timer = -1;
                continue;
            end
            if (intr_timer > 0) intr_timer--;
            if (intr_timer == 0) begin
                ctrl_intr = 1'b1;
                intr_timer = -1;
            end
            if (job_done || timeout) begin
                if (exp_end.size() == 0) begin
                    fail_now($sformatf("end_event unexpected done=%0b timeout=%0b", job_done, timeout));
                end else begin
                    e = exp_end.pop_front();
                    check("end_kind {done,timeout}", 64'({job_done, timeout}),
                          64'((e == 1) ? 2'b01 : 2'b10));
                    if (timeout)
                        check("timeout_latency", 64'(cyc - wait_start), 64'(TO));
                end
            end
            if (sph == 3) begin
                bvalid = 1'b0;
                bresp = 2'b00;
                if (cap_a == 32'h0 && cap_d == 32'h1) begin
                    wait_start = cyc;
                    if (job_dly.size() == 0) begin
                        fail_now("start_without_job");
                    end else begin
                        dl = job_dly.pop_front();
                        if (dl >= 0) intr_timer = dl;
                    end
                end
                if (cap_a == 32'hC) ctrl_intr = 1'b0;
                sph = 0;
            end
            if (sph == 1) begin
                if (awready && wready) begin
                    awready = 1'b0;
                    wready = 1'b0;
                    if (exp_wr.size() == 0)
                        fail_now($sformatf("write_unexpected addr=%0h data=%0h", cap_a, cap_d));
                    else
                        check("write {addr,data}", {cap_a, cap_d}, exp_wr.pop_front());
                    db = int'($urandom_range(0, 3));
                    bc = 0;
                    sph = 2;
                end else begin
                    check("aw_w_held", 64'({awvalid, wvalid}), 64'(2'b11));
                    check("addr_data_stable", {awaddr, wdata}, {cap_a, cap_d});
                    k++;
                    awready = (k >= da);
                    wready = (k >= dw);
                end
            end
            if (sph == 2) begin
                check("single_outstanding {aw,w,bready}", 64'({awvalid, wvalid, bready}), 64'(3'b001));
                if (bc >= db) begin
                    bvalid = 1'b1;
                    if (inject_err && cap_a == 32'h18) begin
                        bresp = 2'b10;
                        inject_err = 1'b0;
                        exp_err = 1'b1;
                    end
                    sph = 3;
                end else begin
                    bc++;
                end
            end
            if (sph == 0 && awvalid) begin
                cap_a = awaddr;
                cap_d = wdata;
                check("wvalid_with_awvalid", 64'(wvalid), 64'(1));
                check("wstrb", 64'(wstrb), 64'(4'hF));
                da = int'($urandom_range(0, 5));
                dw = int'($urandom_range(0, 5));
                k = 0;
                awready = (k >= da);
                wready = (k >= dw);
                sph = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_job(input logic [NR*32-1:0] d, input int dly, output int waited);
        logic acc;
        waited = 0;
        job_valid = 1'b1;
        job_data = d;
        do begin
            acc = job_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 3000);
        job_valid = 1'b0;
        if (acc) expect_job(d, dly);
        else fail_now("push_not_accepted");
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_end.size() != 0 || busy || sph != 0) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) fail_now({name, " drain_timeout"});
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check({name, " busy"}, 64'(busy), 64'(0));
        check({name, " fifo_count"}, 64'(fifo_count), 64'(0));
        check({name, " job_ready"}, 64'(job_ready), 64'(1));
        check({name, " resp_err"}, 64'(resp_err), 64'(exp_err));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " valids {aw,w,bready,ar}"}, 64'({awvalid, wvalid, bready, arvalid}), 64'(0));
        check({name, " rready"}, 64'(rready), 64'(1));
        check({name, " status {busy,done,to,err}"}, 64'({busy, job_done, timeout, resp_err}), 64'(0));
        check({name, " fifo_count"}, 64'(fifo_count), 64'(0));
        check({name, " job_ready"}, 64'(job_ready), 64'(1));
    endtask

    initial begin
        logic [NR*32-1:0] d;
        int w;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        exp_wr.push_back({32'h8, 32'h1});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drain("init");

        // single job, interrupt 50 cycles after WAIT entry
        for (int i = 0; i < NR; i++) d[32*i +: 32] = 32'hA000_0000 + 32'(i);
        push_job(d, 50, w);
        check("first_aw_not_before_idle_decision", 64'(awvalid), 64'(0));
        drain("single");

        // queue full: third push must be held
        for (int i = 0; i < NR; i++) d[32*i +: 32] = 32'hB000_0000 + 32'(i);
        push_job(d, 10, w);
        for (int i = 0; i < NR; i++) d[32*i +: 32] = 32'hB100_0000 + 32'(i);
        push_job(d, 20, w);
        check("full job_ready", 64'(job_ready), 64'(0));
        check("full fifo_count", 64'(fifo_count), 64'(2));
        for (int i = 0; i < NR; i++) d[32*i +: 32] = 32'hB200_0000 + 32'(i);
        push_job(d, 5, w);
        check("third_push_held", 64'(w > 1), 64'(1));
        drain("full");

        // watchdog
        for (int i = 0; i < NR; i++) d[32*i +: 32] = 32'hC000_0000 + 32'(i);
        push_job(d, -1, w);
        drain("watchdog");

        // error response on the third CFG write, then a clean job
        inject_err = 1'b1;
        for (int i = 0; i < NR; i++) d[32*i +: 32] = 32'hD000_0000 + 32'(i);
        push_job(d, 15, w);
        drain("resp_err");
        for (int i = 0; i < NR; i++) d[32*i +: 32] = 32'hD100_0000 + 32'(i);
        push_job(d, 8, w);
        drain("resp_err_sticky");

        // randomized jobs with random gaps
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < NR; i++) d[32*i +: 32] = $urandom;
            push_job(d, int'($urandom_range(1, 60)), w);
            n = int'($urandom_range(0, 25));
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
        drain("random");

        // reset while waiting for the interrupt
        wait_start = -1;
        for (int i = 0; i < NR; i++) d[32*i +: 32] = 32'hE000_0000 + 32'(i);
        push_job(d, 90, w);
        n = 0;
        while (wait_start < 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) fail_now("never_reached_wait");
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        exp_wr.delete();
        exp_end.delete();
        job_dly.delete();
        exp_err = 1'b0;
        inject_err = 1'b0;
        exp_wr.push_back({32'h8, 32'h1});
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drain("after_reset");
        for (int i = 0; i < NR; i++) d[32*i +: 32] = 32'hF000_0000 + 32'(i);
        push_job(d, 12, w);
        drain("post_reset_job");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "time limit");
    end

endmodule
